axis_egress_fifo: RTL and testbench

//  Parametrised egress stage between the parser core and the output AXI-Stream port.

---
 rtl/axis_egress_pkg.sv | 21 ++
 rtl/axis_sdp_ram.sv | 31 +++
 rtl/axis_egress_fifo.sv | 150 +++++++++++++++
 tb/tb_axis_egress_fifo.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_egress_pkg.sv
// ============================================================
// axis_egress_pkg: shared types and helpers for the AXI-Stream egress FIFO.
// Revision: 1.0
// ============================================================
`default_nettype none

package axis_egress_pkg;

  typedef enum logic [0:0] {
    PASS    = 1'b0,
    DISCARD = 1'b1
  } egress_state_t;

  // Saturating increment; the caller passes its counter's all-ones value as max.
  function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input logic [63:0] max);
    return (cnt >= max) ? cnt : cnt + 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_sdp_ram.sv
// ============================================================
// axis_sdp_ram: simple dual-port storage, one synchronous write, one async read.
// Revision: 1.0
// ============================================================
`default_nettype none

module axis_sdp_ram #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/axis_egress_fifo.sv
// ============================================================
// axis_egress_fifo: DEPTH-entry AXI-Stream egress buffer, cut-through or
// store-and-forward with drop of bad/oversize frames. Revision: 1.0
// ============================================================
`default_nettype none

module axis_egress_fifo
  import axis_egress_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 16,
  parameter int PKT_MODE   = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      s_tdata,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic                       s_tlast,
  input  logic [USER_WIDTH-1:0]      s_tuser,
  output logic [DATA_WIDTH-1:0]      m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic [USER_WIDTH-1:0]      m_tuser,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [CNT_WIDTH-1:0]       drop_count,
  output logic                       drop_pulse
);

  localparam int c_ADDR_W  = $clog2(DEPTH);
  localparam int c_PTR_W   = c_ADDR_W + 1;
  localparam int c_ENTRY_W = DATA_WIDTH + USER_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

  logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]   commit_ptr_q, commit_ptr_d;
  logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  egress_state_t        state_q, state_d;
  logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic                 drop_pulse_q, drop_pulse_d;

  logic [c_PTR_W-1:0]   w_used;
  logic                 w_full;
  logic                 w_avail;
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic                 w_mem_we;
  logic [c_ENTRY_W-1:0] w_rd_entry;

  assign w_used   = wr_ptr_q - rd_ptr_q;
  assign w_full   = (w_used == c_PTR_W'(DEPTH));
  assign w_avail  = (commit_ptr_q != rd_ptr_q);

  // Ready is a function of local state only, never of m_tready.
  assign s_tready = !rst && ((state_q == DISCARD) || !w_full);
  assign m_tvalid = !rst && w_avail;
  assign w_wr_en  = s_tvalid && s_tready;
  assign w_rd_en  = m_tvalid && m_tready;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q + c_PTR_W'(w_rd_en);
    state_d      = state_q;
    drop_count_d = drop_count_q;
    drop_pulse_d = 1'b0;
    w_mem_we     = 1'b0;

    if (PKT_MODE == 0) begin
      if (w_wr_en) begin
        w_mem_we     = 1'b1;
        wr_ptr_d     = wr_ptr_q + 1'b1;
        commit_ptr_d = wr_ptr_q + 1'b1;
      end
    end else begin
      case (state_q)
        PASS: begin
          if (w_wr_en) begin
            w_mem_we = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (s_tlast) begin
              if (s_tuser[0]) begin
                wr_ptr_d     = commit_ptr_q;
                drop_pulse_d = 1'b1;
                drop_count_d = CNT_WIDTH'(sat_inc(64'(drop_count_q), 64'(c_CNT_MAX)));
              end else begin
                commit_ptr_d = wr_ptr_q + 1'b1;
              end
            end
          end else if (w_full && !w_avail) begin
            // Buffer holds only the open frame and it still has no tlast: it cannot fit.
            state_d      = DISCARD;
            wr_ptr_d     = commit_ptr_q;
            drop_pulse_d = 1'b1;
            drop_count_d = CNT_WIDTH'(sat_inc(64'(drop_count_q), 64'(c_CNT_MAX)));
          end
        end
        DISCARD: begin
          if (w_wr_en && s_tlast) begin
            state_d = PASS;
          end
        end
        default: state_d = PASS;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      state_q      <= PASS;
      drop_count_q <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      state_q      <= state_d;
      drop_count_q <= drop_count_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  axis_sdp_ram #(
    .WIDTH(c_ENTRY_W),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (w_mem_we),
    .waddr_i(wr_ptr_q[c_ADDR_W-1:0]),
    .wdata_i({s_tuser, s_tlast, s_tdata}),
    .raddr_i(rd_ptr_q[c_ADDR_W-1:0]),
    .rdata_o(w_rd_entry)
  );

  assign m_tdata    = w_rd_entry[DATA_WIDTH-1:0];
  assign m_tlast    = w_rd_entry[DATA_WIDTH];
  assign m_tuser    = w_rd_entry[c_ENTRY_W-1:DATA_WIDTH+1];
  assign fill_level = w_used;
  assign drop_count = drop_count_q;
  assign drop_pulse = drop_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_egress_fifo.sv
// ============================================================
// tb_axis_egress_fifo: directed and randomized checks of both egress modes
// against a frame-level queue model. Revision: 1.0
// ============================================================
`default_nettype none

module tb_axis_egress_fifo;

  localparam int DW      = 64;
  localparam int UW      = 1;
  localparam int DEPTH   = 16;
  localparam int CW      = 16;
  localparam int ENTRY_W = DW + UW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] s_tdata  = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast  = 1'b0;
  logic [UW-1:0] s_tuser  = '0;
  logic          m_tready = 1'b0;
  bit            sel = 1'b0;

  logic          ct_s_tready, ct_m_tvalid, ct_m_tlast, ct_drop_pulse;
  logic [DW-1:0] ct_m_tdata;
  logic [UW-1:0] ct_m_tuser;
  logic [4:0]    ct_fill;
  logic [CW-1:0] ct_drop_count;
  logic          sf_s_tready, sf_m_tvalid, sf_m_tlast, sf_drop_pulse;
  logic [DW-1:0] sf_m_tdata;
  logic [UW-1:0] sf_m_tuser;
  logic [4:0]    sf_fill;
  logic [CW-1:0] sf_drop_count;

  always #5 clk = ~clk;

  axis_egress_fifo #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(DEPTH), .PKT_MODE(0), .CNT_WIDTH(CW)) u_ct (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(ct_s_tready), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tdata(ct_m_tdata), .m_tvalid(ct_m_tvalid), .m_tready(m_tready), .m_tlast(ct_m_tlast), .m_tuser(ct_m_tuser),
    .fill_level(ct_fill), .drop_count(ct_drop_count), .drop_pulse(ct_drop_pulse)
  );

  axis_egress_fifo #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(DEPTH), .PKT_MODE(1), .CNT_WIDTH(CW)) u_sf (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(sf_s_tready), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tdata(sf_m_tdata), .m_tvalid(sf_m_tvalid), .m_tready(m_tready), .m_tlast(sf_m_tlast), .m_tuser(sf_m_tuser),
    .fill_level(sf_fill), .drop_count(sf_drop_count), .drop_pulse(sf_drop_pulse)
  );

  // Observed signals of whichever instance the current test targets
  wire          w_s_tready   = sel ? sf_s_tready   : ct_s_tready;
  wire          w_m_tvalid   = sel ? sf_m_tvalid   : ct_m_tvalid;
  wire          w_m_tlast    = sel ? sf_m_tlast    : ct_m_tlast;
  wire [DW-1:0] w_m_tdata    = sel ? sf_m_tdata    : ct_m_tdata;
  wire [UW-1:0] w_m_tuser    = sel ? sf_m_tuser    : ct_m_tuser;
  wire [4:0]    w_fill       = sel ? sf_fill       : ct_fill;
  wire [CW-1:0] w_drop_count = sel ? sf_drop_count : ct_drop_count;
  wire          w_drop_pulse = sel ? sf_drop_pulse : ct_drop_pulse;

  int errors = 0;
  int checks = 0;

  // Reference model: exp_q holds beats the consumer may see, in order; cur_q the open frame.
  logic [ENTRY_W-1:0] exp_q[$];
  logic [ENTRY_W-1:0] cur_q[$];
  int exp_drops = 0;
  int pulses    = 0;

  task automatic model_clear();
    exp_q.delete();
    cur_q.delete();
    exp_drops = 0;
    pulses    = 0;
  endtask

  task automatic model_accept();
    logic [ENTRY_W-1:0] beat;
    beat = {s_tuser, s_tlast, s_tdata};
    if (!sel) begin
      exp_q.push_back(beat);
    end else begin
      cur_q.push_back(beat);
      if (s_tlast) begin
        if (s_tuser[0] || cur_q.size() > DEPTH) exp_drops++;
        else foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
        cur_q.delete();
      end
    end
  endtask

  // Called at a falling edge with inputs set for the next rising edge.
  task automatic clock_step(output bit acc);
    logic [ENTRY_W-1:0] obs;
    acc = 1'b0;
    checks++;
    if (w_m_tvalid !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL m_tvalid: got %b, expected %b (t=%0t)", w_m_tvalid, exp_q.size() != 0, $time);
    end
    if (w_m_tvalid === 1'b1 && exp_q.size() != 0) begin
      obs = {w_m_tuser, w_m_tlast, w_m_tdata};
      checks++;
      if (obs !== exp_q[0]) begin
        errors++;
        $display("FAIL out_beat: got %h, expected %h (t=%0t)", obs, exp_q[0], $time);
      end
      if (m_tready) void'(exp_q.pop_front());
    end
    if (w_drop_pulse === 1'b1) pulses++;
    if (s_tvalid && w_s_tready === 1'b1) begin
      acc = 1'b1;
      model_accept();
    end
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit last, input bit user, output bit ok);
    bit acc;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = last; s_tuser = user;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      clock_step(acc);
      ok = acc;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int c;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      clock_step(acc);
      c++;
    end
    clock_step(acc);
    m_tready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats left, expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = '0; m_tready = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({ct_s_tready, ct_m_tvalid, sf_s_tready, sf_m_tvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_handshake: got %b, expected 0000", {ct_s_tready, ct_m_tvalid, sf_s_tready, sf_m_tvalid});
    end
    do_reset();
    checks++;
    if ({ct_fill, sf_fill, ct_drop_count, sf_drop_count, ct_drop_pulse, sf_drop_pulse} !== '0) begin
      errors++;
      $display("FAIL reset_state: fill %0d/%0d drops %0d/%0d pulse %b/%b, expected all 0",
               ct_fill, sf_fill, ct_drop_count, sf_drop_count, ct_drop_pulse, sf_drop_pulse);
    end
    checks++;
    if ({ct_s_tready, sf_s_tready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready: got %b, expected 11", {ct_s_tready, sf_s_tready});
    end
  endtask

  task automatic test_ct_hold();
    bit ok, acc;
    sel = 1'b0;
    do_reset();
    send_beat(64'hDEADBEEFCAFEBABE, 1'b1, 1'b0, ok);
    for (int i = 0; i < 6; i++) clock_step(acc);
    drain();
  endtask

  task automatic test_ct_full();
    bit ok, acc;
    int n;
    sel = 1'b0;
    do_reset();
    n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      send_beat(64'(i) | 64'hA500_0000_0000_0000, 1'b0, 1'b0, ok);
      if (ok) n++;
    end
    checks++;
    if (n != DEPTH || w_fill !== 5'(DEPTH)) begin
      errors++;
      $display("FAIL ct_fill: accepted %0d fill %0d, expected %0d", n, w_fill, DEPTH);
    end
    s_tvalid = 1'b1; s_tdata = 64'hA500_0000_0000_0010; s_tlast = 1'b1; s_tuser = '0;
    for (int i = 0; i < 3; i++) clock_step(acc);
    checks++;
    if (w_s_tready !== 1'b0) begin
      errors++;
      $display("FAIL ct_full_ready: got %b, expected 0", w_s_tready);
    end
    m_tready = 1'b1;
    clock_step(acc);
    checks++;
    if (w_s_tready !== 1'b1 || acc) begin
      errors++;
      $display("FAIL ct_free_slot: ready %b acc %b, expected ready 1 acc 0", w_s_tready, acc);
    end
    clock_step(acc);
    s_tvalid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL ct_beat16_accept: got %b, expected 1", acc);
    end
    drain();
  endtask

  task automatic test_sf_frames();
    bit ok;
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) send_beat(64'h1000 + 64'(i), i == 3, 1'b0, ok);
    checks++;
    if (w_fill !== 5'd4) begin
      errors++;
      $display("FAIL sf_fill4: got %0d, expected 4", w_fill);
    end
    drain();
    for (int i = 0; i < 3; i++) send_beat(64'h2000 + 64'(i), i == 2, i == 2, ok);
    for (int i = 0; i < 2; i++) send_beat(64'h3000 + 64'(i), i == 1, 1'b0, ok);
    drain();
    checks++;
    if (w_drop_count !== 16'd1 || pulses != 1) begin
      errors++;
      $display("FAIL sf_bad_drop: count %0d pulses %0d, expected 1 and 1", w_drop_count, pulses);
    end
  endtask

  task automatic test_sf_oversize();
    bit ok;
    int n;
    sel = 1'b1;
    do_reset();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      send_beat(64'h4000 + 64'(i), i == 19, 1'b0, ok);
      if (ok) n++;
    end
    checks++;
    if (n != 20 || w_drop_count !== 16'd1 || w_fill !== 5'd0 || pulses != 1) begin
      errors++;
      $display("FAIL sf_oversize: accepted %0d drops %0d fill %0d pulses %0d, expected 20 1 0 1",
               n, w_drop_count, w_fill, pulses);
    end
    for (int i = 0; i < DEPTH; i++) send_beat(64'h5000 + 64'(i), i == DEPTH - 1, 1'b0, ok);
    checks++;
    if (w_fill !== 5'(DEPTH) || w_drop_count !== 16'd1) begin
      errors++;
      $display("FAIL sf_exact_depth: fill %0d drops %0d, expected %0d and 1", w_fill, w_drop_count, DEPTH);
    end
    drain();
  endtask

  task automatic test_reset_midframe();
    bit ok;
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) send_beat(64'h6000 + 64'(i), 1'b0, 1'b0, ok);
    rst = 1'b1;
    #1;
    checks++;
    if (w_m_tvalid !== 1'b0 || w_fill !== 5'd0 || w_s_tready !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: valid %b fill %0d ready %b, expected 0 0 0", w_m_tvalid, w_fill, w_s_tready);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) send_beat(64'h7000 + 64'(i), i == 1, 1'b0, ok);
    drain();
  endtask

  task automatic test_random(input bit sf, input int nframes, input int bad_pct, input int valid_pct, input int ready_pct);
    int f, b, len, cyc;
    bit pending, acc, bad;
    sel = sf;
    do_reset();
    f = 0; b = 0; cyc = 0; pending = 1'b0;
    len = $urandom_range(1, 20);
    bad = ($urandom_range(0, 99) < bad_pct);
    while (f < nframes && cyc < 20000) begin
      if (!pending) begin
        if ($urandom_range(0, 99) < valid_pct) begin
          s_tvalid = 1'b1;
          s_tdata  = {f[15:0], b[15:0], 32'($urandom)};
          s_tlast  = (b == len - 1);
          s_tuser  = s_tlast ? 1'(bad) : 1'($urandom);
          pending  = 1'b1;
        end else begin
          s_tvalid = 1'b0;
        end
      end
      m_tready = ($urandom_range(0, 99) < ready_pct);
      clock_step(acc);
      cyc++;
      if (acc) begin
        pending = 1'b0;
        if (b == len - 1) begin
          f++;
          b = 0;
          len = $urandom_range(1, 20);
          bad = ($urandom_range(0, 99) < bad_pct);
        end else begin
          b++;
        end
      end
    end
    s_tvalid = 1'b0;
    checks++;
    if (f != nframes) begin
      errors++;
      $display("FAIL rand_progress: sent %0d frames, expected %0d", f, nframes);
    end
    drain();
    checks++;
    if (w_drop_count !== CW'(exp_drops) || pulses != exp_drops) begin
      errors++;
      $display("FAIL rand_drops(mode %0d): count %0d pulses %0d, expected %0d", sf, w_drop_count, pulses, exp_drops);
    end
  endtask

  initial begin
    test_reset();
    test_ct_hold();
    test_ct_full();
    test_sf_frames();
    test_sf_oversize();
    test_reset_midframe();
    test_random(1'b0, 40, 20, 80, 60);
    test_random(1'b1, 40, 20, 80, 60);
    test_random(1'b1, 30, 10, 100, 30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
